pixel_bank_loader: RTL and testbench

- Write-side counterpart of the 50:1 pixel selector: it fills the 50-entry pixel bank the selector reads from.
- Accepts a serial pixel stream over a valid/ready handshake and writes each pixel into the next slot (0..49).
- Presents the whole bank as a flat parallel bus, then raises Bank_Valid and holds the bank frozen until the consumer acknowledges.
- Sits between the pixel input stream and the selector / processing stage.

---
 rtl/pixel_bank_loader.sv | 94 +++++++++
 tb/tb_pixel_bank_loader.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/pixel_bank_loader.sv
// Write side of the 50:1 pixel selector: fills the pixel bank from a serial
// valid/ready stream and freezes it behind Bank_Valid until Bank_Ack.
`ifndef PIX_WIDTH
`define PIX_WIDTH 8
`endif

module pixel_bank_loader #(
  parameter int PIX_WIDTH = `PIX_WIDTH,
  parameter int NUM_PIX   = 50
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [PIX_WIDTH-1:0]         In_Pixel,
  input  logic                         In_Valid,
  input  logic                         In_SOF,
  output logic                         In_Ready,
  input  logic                         Bank_Ack,
  output logic [NUM_PIX*PIX_WIDTH-1:0] Pixel_Bank,
  output logic [5:0]                   Wr_Index,
  output logic                         Bank_Valid,
  output logic                         Sync_Err
);

  typedef enum logic {FILL, FULL} state_t;

  localparam logic [5:0] LAST_IDX = 6'(NUM_PIX - 1);

  state_t               state, state_nxt;
  logic [5:0]           wr_index_nxt;
  logic                 sync_err_nxt;
  logic                 accept;
  logic [NUM_PIX-1:0]   slot_we;
  logic [PIX_WIDTH-1:0] slots [NUM_PIX];

  assign In_Ready   = (state == FILL) && !rst;
  assign accept     = In_Valid && In_Ready;
  assign Bank_Valid = (state == FULL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= FILL;
      Wr_Index <= '0;
      Sync_Err <= 1'b0;
    end else begin
      state    <= state_nxt;
      Wr_Index <= wr_index_nxt;
      Sync_Err <= sync_err_nxt;
    end
  end

  // A start-of-frame always restarts at slot 0; it only counts as a resync
  // when it interrupts a partially filled bank.
  always_comb begin
    state_nxt    = state;
    wr_index_nxt = Wr_Index;
    sync_err_nxt = 1'b0;
    case (state)
      FILL: begin
        if (accept) begin
          if (In_SOF) begin
            sync_err_nxt = (Wr_Index != 6'd0);
            if (NUM_PIX == 1) begin
              wr_index_nxt = 6'd0;
              state_nxt    = FULL;
            end else begin
              wr_index_nxt = 6'd1;
            end
          end else if (Wr_Index == LAST_IDX) begin
            wr_index_nxt = 6'd0;
            state_nxt    = FULL;
          end else begin
            wr_index_nxt = Wr_Index + 6'd1;
          end
        end
      end
      FULL: begin
        if (Bank_Ack) state_nxt = FILL;
      end
      default: state_nxt = FILL;
    endcase
  end

  for (genvar k = 0; k < NUM_PIX; k++) begin : g_slot
    assign slot_we[k] = accept && (In_SOF ? (k == 0) : (Wr_Index == 6'(k)));

    always_ff @(posedge clk or posedge rst) begin
      if (rst)             slots[k] <= '0;
      else if (slot_we[k]) slots[k] <= In_Pixel;
    end

    assign Pixel_Bank[k*PIX_WIDTH +: PIX_WIDTH] = slots[k];
  end

endmodule

// File: tb/tb_pixel_bank_loader.sv
// Directed self-checking bench for pixel_bank_loader (PIX_WIDTH=8, NUM_PIX=50).
module tb_pixel_bank_loader;

  localparam int PW = 8;
  localparam int NP = 50;
  localparam int BW = PW * NP;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [PW-1:0] In_Pixel = '0;
  logic          In_Valid = 1'b0;
  logic          In_SOF = 1'b0;
  logic          In_Ready;
  logic          Bank_Ack = 1'b0;
  logic [BW-1:0] Pixel_Bank;
  logic [5:0]    Wr_Index;
  logic          Bank_Valid;
  logic          Sync_Err;

  int            num_checks = 0;
  int            num_passed = 0;

  logic [BW-1:0] exp_bank = '0;
  int            exp_idx  = 0;
  logic          exp_full = 1'b0;

  pixel_bank_loader #(.PIX_WIDTH(PW), .NUM_PIX(NP)) dut (
    .clk        (clk),
    .rst        (rst),
    .In_Pixel   (In_Pixel),
    .In_Valid   (In_Valid),
    .In_SOF     (In_SOF),
    .In_Ready   (In_Ready),
    .Bank_Ack   (Bank_Ack),
    .Pixel_Bank (Pixel_Bank),
    .Wr_Index   (Wr_Index),
    .Bank_Valid (Bank_Valid),
    .Sync_Err   (Sync_Err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [BW-1:0] got,
                             input logic [BW-1:0] exp);
    num_checks++;
    if (got === exp) num_passed++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Drives one valid beat and updates the expected-bank model as if accepted.
  task automatic applyStimulus(input logic [PW-1:0] pix, input logic sof);
    In_Valid = 1'b1;
    In_Pixel = pix;
    In_SOF   = sof;
    if (!exp_full) begin
      if (sof) begin
        exp_bank[0 +: PW] = pix;
        exp_idx = 1;
      end else begin
        exp_bank[exp_idx*PW +: PW] = pix;
        if (exp_idx == NP - 1) begin
          exp_idx  = 0;
          exp_full = 1'b1;
        end else begin
          exp_idx++;
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic idleCycle();
    In_Valid = 1'b0;
    In_SOF   = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic asyncReset();
    In_Valid = 1'b0;
    In_SOF   = 1'b0;
    #2 rst = 1'b1;
    #1;
    exp_bank = '0;
    exp_idx  = 0;
    exp_full = 1'b0;
    checkOutput("rst_bank",  Pixel_Bank, '0);
    checkOutput("rst_idx",   BW'(Wr_Index), BW'(0));
    checkOutput("rst_valid", BW'(Bank_Valid), BW'(0));
    checkOutput("rst_ready", BW'(In_Ready), BW'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checkOutput("rst_ready_rel", BW'(In_Ready), BW'(1));
  endtask

  initial begin
    // Power-on reset
    @(posedge clk); @(posedge clk); #1;
    checkOutput("por_bank",  Pixel_Bank, '0);
    checkOutput("por_idx",   BW'(Wr_Index), BW'(0));
    checkOutput("por_valid", BW'(Bank_Valid), BW'(0));
    checkOutput("por_ready", BW'(In_Ready), BW'(0));
    checkOutput("por_sync",  BW'(Sync_Err), BW'(0));
    rst = 1'b0;
    #1;
    checkOutput("por_ready_rel", BW'(In_Ready), BW'(1));

    // Reset mid-stream after 20 accepts
    for (int k = 0; k < 20; k++) applyStimulus(8'h50 + 8'(k), k == 0);
    checkOutput("mid_idx20", BW'(Wr_Index), BW'(20));
    checkOutput("mid_bank",  Pixel_Bank, exp_bank);
    asyncReset();

    // Gap-free full fill 0x10..0x41
    for (int k = 0; k < NP; k++) begin
      if (k == NP - 1) checkOutput("fill_valid_pre", BW'(Bank_Valid), BW'(0));
      applyStimulus(8'h10 + 8'(k), k == 0);
    end
    checkOutput("fill_valid", BW'(Bank_Valid), BW'(1));
    checkOutput("fill_ready", BW'(In_Ready), BW'(0));
    checkOutput("fill_idx",   BW'(Wr_Index), BW'(0));
    checkOutput("fill_bank",  Pixel_Bank, exp_bank);
    checkOutput("fill_slot49", BW'(Pixel_Bank[49*PW +: PW]), BW'(8'h41));

    // Hold while FULL with garbage on the input
    In_Valid = 1'b1;
    In_Pixel = 8'hFF;
    In_SOF   = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
    end
    checkOutput("hold_bank",  Pixel_Bank, exp_bank);
    checkOutput("hold_idx",   BW'(Wr_Index), BW'(0));
    checkOutput("hold_valid", BW'(Bank_Valid), BW'(1));
    Bank_Ack = 1'b1;
    @(posedge clk); #1;
    Bank_Ack = 1'b0;
    exp_full = 1'b0;
    checkOutput("ack_valid", BW'(Bank_Valid), BW'(0));
    checkOutput("ack_ready", BW'(In_Ready), BW'(1));
    checkOutput("ack_bank_kept", Pixel_Bank, exp_bank);
    applyStimulus(8'h99, 1'b0);
    checkOutput("next_slot0", BW'(Pixel_Bank[0 +: PW]), BW'(8'h99));
    checkOutput("next_slot1", BW'(Pixel_Bank[PW +: PW]), BW'(8'h11));

    // Resync after 17 accepts
    for (int k = 1; k < 17; k++) applyStimulus(8'h60 + 8'(k), 1'b0);
    checkOutput("resync_pre_idx",  BW'(Wr_Index), BW'(17));
    checkOutput("resync_pre_sync", BW'(Sync_Err), BW'(0));
    applyStimulus(8'hAA, 1'b1);
    checkOutput("resync_sync",  BW'(Sync_Err), BW'(1));
    checkOutput("resync_idx",   BW'(Wr_Index), BW'(1));
    checkOutput("resync_slot0", BW'(Pixel_Bank[0 +: PW]), BW'(8'hAA));
    checkOutput("resync_bank",  Pixel_Bank, exp_bank);
    idleCycle();
    checkOutput("resync_pulse_end", BW'(Sync_Err), BW'(0));

    // Bubbled frame must produce the same bank as the gap-free one
    asyncReset();
    for (int k = 0; k < NP; k++) begin
      if ($urandom_range(0, 1) == 1) idleCycle();
      if (k == NP - 1) begin
        idleCycle();
        checkOutput("bub_valid_pre", BW'(Bank_Valid), BW'(0));
      end
      applyStimulus(8'h10 + 8'(k), k == 0);
    end
    In_Valid = 1'b0;
    checkOutput("bub_valid", BW'(Bank_Valid), BW'(1));
    checkOutput("bub_bank",  Pixel_Bank, exp_bank);

    // Level-held Bank_Ack: one release per FULL entry, ignored in FILL
    Bank_Ack = 1'b1;
    @(posedge clk); #1;
    exp_full = 1'b0;
    checkOutput("lvl_release", BW'(Bank_Valid), BW'(0));
    applyStimulus(8'h21, 1'b1);
    checkOutput("sof0_nosync", BW'(Sync_Err), BW'(0));
    checkOutput("sof0_idx",    BW'(Wr_Index), BW'(1));
    for (int k = 1; k < NP; k++) begin
      if (k == NP - 1) checkOutput("lvl_fill_valid", BW'(Bank_Valid), BW'(0));
      applyStimulus(8'h21 + 8'(k), 1'b0);
    end
    In_Valid = 1'b0;
    checkOutput("lvl_full",  BW'(Bank_Valid), BW'(1));
    checkOutput("lvl_bank",  Pixel_Bank, exp_bank);
    @(posedge clk); #1;
    exp_full = 1'b0;
    checkOutput("lvl_release2", BW'(Bank_Valid), BW'(0));
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
    end
    checkOutput("lvl_stay_fill", BW'(Bank_Valid), BW'(0));
    checkOutput("lvl_ready",     BW'(In_Ready), BW'(1));
    checkOutput("lvl_idx",       BW'(Wr_Index), BW'(0));
    Bank_Ack = 1'b0;

    $display("%0d/%0d checks passed", num_passed, num_checks);
    $finish;
  end

endmodule
